// File: rtl/controller_sequencer.sv
// SAP control unit: six-state ring counter (T1..T6) with a halt state and an
// opcode decoder that drives the active-low bus load/enable strobes.
module controller_sequencer (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] OPCODE,
    output logic       INC_PC,
    output logic       _EN_PC_OUT,
    output logic       _EN_MAR_IN,
    output logic       _EN_RAM_OUT,
    output logic       _EN_IR_IN,
    output logic       _EN_IR_OUT,
    output logic       _EN_ACC_IN,
    output logic       _EN_ACC_OUT,
    output logic       _EN_B_IN,
    output logic       _EN_ULA_OUT,
    output logic       SUB,
    output logic       _EN_OUT_IN,
    output logic       HALT,
    output logic [5:0] T_STATE
);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_T1     = 3'd0,
        S_T2     = 3'd1,
        S_T3     = 3'd2,
        S_T4     = 3'd3,
        S_T5     = 3'd4,
        S_T6     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register; reset restarts the ring from any state, including HALTED.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= S_T1;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control-word decode; the control word is forced inactive while RESET is high.
    always_comb begin
        state_nxt   = state;
        INC_PC      = 1'b0;
        _EN_PC_OUT  = 1'b1;
        _EN_MAR_IN  = 1'b1;
        _EN_RAM_OUT = 1'b1;
        _EN_IR_IN   = 1'b1;
        _EN_IR_OUT  = 1'b1;
        _EN_ACC_IN  = 1'b1;
        _EN_ACC_OUT = 1'b1;
        _EN_B_IN    = 1'b1;
        _EN_ULA_OUT = 1'b1;
        SUB         = 1'b0;
        _EN_OUT_IN  = 1'b1;
        HALT        = 1'b0;
        T_STATE     = 6'b000000;

        case (state)
            S_T1: begin
                state_nxt = S_T2;
                T_STATE   = 6'b000001;
                if (!RESET) begin
                    _EN_PC_OUT = 1'b0;
                    _EN_MAR_IN = 1'b0;
                end
            end
            S_T2: begin
                state_nxt = S_T3;
                T_STATE   = 6'b000010;
                if (!RESET) begin
                    INC_PC = 1'b1;
                end
            end
            S_T3: begin
                state_nxt = S_T4;
                T_STATE   = 6'b000100;
                if (!RESET) begin
                    _EN_RAM_OUT = 1'b0;
                    _EN_IR_IN   = 1'b0;
                end
            end
            S_T4: begin
                state_nxt = (OPCODE == OP_HLT) ? S_HALTED : S_T5;
                T_STATE   = 6'b001000;
                if (!RESET) begin
                    case (OPCODE)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            _EN_IR_OUT = 1'b0;
                            _EN_MAR_IN = 1'b0;
                        end
                        OP_OUT: begin
                            _EN_ACC_OUT = 1'b0;
                            _EN_OUT_IN  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_T5: begin
                state_nxt = S_T6;
                T_STATE   = 6'b010000;
                if (!RESET) begin
                    case (OPCODE)
                        OP_LDA: begin
                            _EN_RAM_OUT = 1'b0;
                            _EN_ACC_IN  = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            _EN_RAM_OUT = 1'b0;
                            _EN_B_IN    = 1'b0;
                            SUB         = (OPCODE == OP_SUB);
                        end
                        default: ;
                    endcase
                end
            end
            S_T6: begin
                state_nxt = S_T1;
                T_STATE   = 6'b100000;
                if (!RESET) begin
                    if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                        _EN_ULA_OUT = 1'b0;
                        _EN_ACC_IN  = 1'b0;
                        SUB         = (OPCODE == OP_SUB);
                    end
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
                HALT      = 1'b1;
            end
            default: begin
                state_nxt = S_T1;
            end
        endcase
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed, table-driven bench for controller_sequencer: one record per clock
// cycle, plus hand-written halt-sweep and bus-exclusivity checks.
module tb_controller_sequencer;

    logic       CLOCK;
    logic       RESET;
    logic [3:0] OPCODE;
    logic       inc_pc, en_pc_out, en_mar_in, en_ram_out, en_ir_in, en_ir_out;
    logic       en_acc_in, en_acc_out, en_b_in, en_ula_out, sub, en_out_in, halt;
    logic [5:0] t_state;

    controller_sequencer dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .OPCODE      (OPCODE),
        .INC_PC      (inc_pc),
        ._EN_PC_OUT  (en_pc_out),
        ._EN_MAR_IN  (en_mar_in),
        ._EN_RAM_OUT (en_ram_out),
        ._EN_IR_IN   (en_ir_in),
        ._EN_IR_OUT  (en_ir_out),
        ._EN_ACC_IN  (en_acc_in),
        ._EN_ACC_OUT (en_acc_out),
        ._EN_B_IN    (en_b_in),
        ._EN_ULA_OUT (en_ula_out),
        .SUB         (sub),
        ._EN_OUT_IN  (en_out_in),
        .HALT        (halt),
        .T_STATE     (t_state)
    );

    // Asserted-strobe mask, one bit per control signal regardless of polarity.
    localparam logic [11:0] A_INC  = 12'h800;
    localparam logic [11:0] A_PCO  = 12'h400;
    localparam logic [11:0] A_MARI = 12'h200;
    localparam logic [11:0] A_RAMO = 12'h100;
    localparam logic [11:0] A_IRI  = 12'h080;
    localparam logic [11:0] A_IRO  = 12'h040;
    localparam logic [11:0] A_ACCI = 12'h020;
    localparam logic [11:0] A_ACCO = 12'h010;
    localparam logic [11:0] A_BI   = 12'h008;
    localparam logic [11:0] A_ULAO = 12'h004;
    localparam logic [11:0] A_SUB  = 12'h002;
    localparam logic [11:0] A_OUTI = 12'h001;
    localparam logic [11:0] NONE   = 12'h000;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
    localparam logic [5:0] TH = 6'b000000;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic [11:0] act;
        logic        halt;
        logic [5:0]  ts;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [11:0] act_now;
    assign act_now = {inc_pc, ~en_pc_out, ~en_mar_in, ~en_ram_out, ~en_ir_in, ~en_ir_out,
                      ~en_acc_in, ~en_acc_out, ~en_b_in, ~en_ula_out, sub, ~en_out_in};

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic add(input logic rst, input logic [3:0] op, input logic [11:0] act,
                       input logic hlt, input logic [5:0] ts);
        vec_t v;
        v.rst  = rst;
        v.op   = op;
        v.act  = act;
        v.halt = hlt;
        v.ts   = ts;
        vecs.push_back(v);
    endtask

    // Standard fetch cycles (opcode is don't-care here).
    task automatic add_fetch(input logic [3:0] op);
        add(1'b0, op, A_PCO | A_MARI, 1'b0, T1);
        add(1'b0, op, A_INC,          1'b0, T2);
        add(1'b0, op, A_RAMO | A_IRI, 1'b0, T3);
    endtask

    task automatic check(input string name, input logic [11:0] act,
                         input logic hlt, input logic [5:0] ts);
        checks++;
        if (act_now !== act || halt !== hlt || t_state !== ts) begin
            errors++;
            $display("FAIL %s: act=%03h halt=%b t_state=%06b, required act=%03h halt=%b t_state=%06b",
                     name, act_now, halt, t_state, act, hlt, ts);
        end
    endtask

    // At most one bus driver may be enabled in any cycle.
    always @(negedge CLOCK) begin
        checks++;
        if ($countones({~en_pc_out, ~en_ram_out, ~en_ir_out, ~en_acc_out, ~en_ula_out}) > 1) begin
            errors++;
            $display("FAIL bus_excl: pc=%b ram=%b ir=%b acc=%b ula=%b, required at most one low",
                     en_pc_out, en_ram_out, en_ir_out, en_acc_out, en_ula_out);
        end
    end

    initial begin
        RESET  = 1'b1;
        OPCODE = 4'h0;

        // Reset held two cycles: inactive word, T1 state
        add(1'b1, 4'h0, NONE, 1'b0, T1);
        add(1'b1, 4'h0, NONE, 1'b0, T1);
        // LDA
        add_fetch(4'h0);
        add(1'b0, 4'h0, A_IRO | A_MARI,  1'b0, T4);
        add(1'b0, 4'h0, A_RAMO | A_ACCI, 1'b0, T5);
        add(1'b0, 4'h0, NONE,            1'b0, T6);
        // ADD
        add_fetch(4'h1);
        add(1'b0, 4'h1, A_IRO | A_MARI,  1'b0, T4);
        add(1'b0, 4'h1, A_RAMO | A_BI,   1'b0, T5);
        add(1'b0, 4'h1, A_ULAO | A_ACCI, 1'b0, T6);
        // SUB
        add_fetch(4'h2);
        add(1'b0, 4'h2, A_IRO | A_MARI,          1'b0, T4);
        add(1'b0, 4'h2, A_RAMO | A_BI | A_SUB,   1'b0, T5);
        add(1'b0, 4'h2, A_ULAO | A_ACCI | A_SUB, 1'b0, T6);
        // OUT
        add_fetch(4'hE);
        add(1'b0, 4'hE, A_ACCO | A_OUTI, 1'b0, T4);
        add(1'b0, 4'hE, NONE,            1'b0, T5);
        add(1'b0, 4'hE, NONE,            1'b0, T6);
        // Undefined opcode; HLT during fetch must not halt
        add_fetch(4'hF);
        add(1'b0, 4'h7, NONE, 1'b0, T4);
        add(1'b0, 4'h7, NONE, 1'b0, T5);
        add(1'b0, 4'h7, NONE, 1'b0, T6);
        // Opcode change inside T4..T6 is seen the same cycle; HLT in T6 is a nop
        add_fetch(4'h0);
        add(1'b0, 4'h0, A_IRO | A_MARI,        1'b0, T4);
        add(1'b0, 4'h2, A_RAMO | A_BI | A_SUB, 1'b0, T5);
        add(1'b0, 4'hF, NONE,                  1'b0, T6);
        // Reset during ADD T5
        add_fetch(4'h1);
        add(1'b0, 4'h1, A_IRO | A_MARI, 1'b0, T4);
        add(1'b1, 4'h1, NONE,           1'b0, T5);
        // Fresh instruction, then HLT in T4
        add_fetch(4'h1);
        add(1'b0, 4'hF, NONE, 1'b0, T4);
        add(1'b0, 4'hF, NONE, 1'b1, TH);

        @(posedge CLOCK);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLOCK);
            RESET  = vecs[i].rst;
            OPCODE = vecs[i].op;
            #1;
            check($sformatf("vec%0d", i), vecs[i].act, vecs[i].halt, vecs[i].ts);
        end

        // HALTED holds across every opcode
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            OPCODE = 4'(i);
            #1;
            check($sformatf("halt_sweep%0d", i), NONE, 1'b1, TH);
        end

        // Reset from HALTED: state changes only at the edge that samples RESET
        @(negedge CLOCK);
        RESET  = 1'b1;
        OPCODE = 4'h3;
        #1;
        check("halted_rst", NONE, 1'b1, TH);
        @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        check("post_halt_t1", A_PCO | A_MARI, 1'b0, T1);
        @(negedge CLOCK);
        #1;
        check("post_halt_t2", A_INC, 1'b0, T2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit for the SAP bus machine: a 6-state ring counter (T1..T6) plus an opcode decoder.
- Drives the active-low load/enable strobes consumed by the accumulator, B, MAR, IR, RAM, PC, ULA and output registers.
- It is the initiator side of the register enable interface: it generates every _EN_xxx_IN / _EN_xxx_OUT that the bus registers sample at the rising clock edge.

Parameters:
OP_LDA, 4'h0, opcode for load accumulator from memory
OP_ADD, 4'h1, opcode for ACC = ACC + mem
OP_SUB, 4'h2, opcode for ACC = ACC - mem
OP_OUT, 4'hE, opcode for copying ACC to the output register
OP_HLT, 4'hF, opcode for halt

Ports:
CLOCK  input  1  system clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset
OPCODE  input  4  IR high nibble; stable from T4 through T6
INC_PC  output  1  active-high PC increment (Cp)
_EN_PC_OUT  output  1  active-low PC to bus (Ep)
_EN_MAR_IN  output  1  active-low MAR load (Lm)
_EN_RAM_OUT  output  1  active-low RAM to bus (CE)
_EN_IR_IN  output  1  active-low IR load (Li)
_EN_IR_OUT  output  1  active-low IR operand nibble to bus (Ei)
_EN_ACC_IN  output  1  active-low accumulator load (La)
_EN_ACC_OUT  output  1  active-low accumulator to bus (Ea)
_EN_B_IN  output  1  active-low B register load (Lb)
_EN_ULA_OUT  output  1  active-low ULA result to bus (Eu)
SUB  output  1  ULA mode: 1 = subtract, 0 = add
_EN_OUT_IN  output  1  active-low output register load (Lo)
HALT  output  1  high while halted
T_STATE  output  6  one-hot ring state; bit0 = T1 ... bit5 = T6

Behaviour:
- State: a one-hot ring T1->T2->...->T6->T1, plus a HALTED state. The ring advances one step per rising edge.
- All control outputs are combinational from the current state and OPCODE. The destination register therefore latches at the rising edge that ends the T-state. Latency from state entry to strobe is zero cycles.
- Inactive control word: all _EN_* = 1, INC_PC = 0, SUB = 0.
- Asserted strobes per state (everything not listed is inactive):
  - T1: _EN_PC_OUT, _EN_MAR_IN.
  - T2: INC_PC.
  - T3: _EN_RAM_OUT, _EN_IR_IN.
  - LDA: T4 _EN_IR_OUT + _EN_MAR_IN; T5 _EN_RAM_OUT + _EN_ACC_IN; T6 nop.
  - ADD: T4 _EN_IR_OUT + _EN_MAR_IN; T5 _EN_RAM_OUT + _EN_B_IN; T6 _EN_ULA_OUT + _EN_ACC_IN, SUB = 0.
  - SUB: as ADD, except SUB = 1 in T5 and T6, so the ULA settles before the T6 edge.
  - OUT: T4 _EN_ACC_OUT + _EN_OUT_IN; T5 and T6 nop.
  - Undefined opcode: T4..T6 nop; the ring continues normally.
- Halt:
  - HLT in T4: control word inactive during that cycle; the next edge enters HALTED.
  - HALTED: HALT = 1, T_STATE = 0, control word inactive, held regardless of OPCODE until RESET.
- Bus exclusivity: at most one _EN_*_OUT is low in any cycle, including during reset. The bench asserts this every cycle.
- Reset:
  - The cycle RESET is sampled high, the next state is T1 with HALT = 0, from any state, mid-instruction or HALTED.
  - While RESET is high, the control word is forced inactive combinationally.
  - Post-reset values: T_STATE = 6'b000001, HALT = 0, all _EN_* = 1, INC_PC = 0, SUB = 0.
  - T1 strobes appear on the first cycle after RESET deasserts.
- OPCODE is ignored in T1..T3. OPCODE changes in T4..T6 take effect the same cycle; there is no internal latch.
- Instruction length is fixed at 6 cycles: no early termination.

Test Plan:
- Reset: RESET = 1 for 2 cycles -> T_STATE = 000001, all _EN_* = 1, INC_PC = 0, HALT = 0. After release, T1 shows _EN_PC_OUT = 0 and _EN_MAR_IN = 0.
- LDA with OPCODE = 4'h0 over 6 cycles:
  - T4: _EN_IR_OUT = _EN_MAR_IN = 0.
  - T5: _EN_RAM_OUT = _EN_ACC_IN = 0.
  - T6: all inactive.
  - Next state T1.
- ADD (4'h1) then SUB (4'h2):
  - T5: _EN_B_IN = 0.
  - T6: _EN_ULA_OUT = _EN_ACC_IN = 0.
  - SUB = 0 for ADD; SUB = 1 in T5..T6 for SUB.
- OUT (4'hE) -> T4 has _EN_ACC_OUT = _EN_OUT_IN = 0; T5/T6 nop.
- HLT (4'hF) -> HALT = 1 from the cycle after T4. Sweep OPCODE through 0..F for 20 cycles -> state held, strobes inactive. RESET -> T1.
- Reset mid-instruction: assert RESET during ADD T5 -> strobes inactive that cycle, T_STATE = 000001 next. Also check the undefined opcode 4'h7 runs 6 cycles with T4..T6 inactive.
